// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e : MDUOp encodings driven by the decoder. Start is raised for
//              MULT..DIVU only. MTHI/MTLO arrive with Start low.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Bus between the E stage and the multiply/divide unit.
//   Start, MDUOp, A, B, Req : E-stage request side (master drives)
//   Busy, HI, LO            : unit status and architectural HI/LO (slave drives)
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic        Start;
  mdu_op_e     MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, Req, input Busy, HI, LO);
  modport slave  (input Start, MDUOp, A, B, Req, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with the architectural HI/LO registers.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : mult_div_unit_if.slave (Start, MDUOp, A, B, Req in; Busy, HI, LO out)
// The 64-bit result is computed combinationally when an operation is accepted
// and parked in pending registers; a counter then models the fixed latency and
// the result is committed to HI/LO on the edge the counter reaches zero.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             is_mul, is_div, is_sgn;
  logic [63:0]      res;

  // 32x32 -> 64 product; operands are sign- or zero-extended to 64 bits so a
  // plain unsigned multiply gives the correct low 64 bits in both cases.
  function automatic logic [63:0] mul_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // 0x80000000 / -1 case falls out naturally (quotient 0x80000000, rem 0)
  // without relying on signed-overflow behaviour of the '/' operator.
  // A zero divisor is replaced by 1 only to keep the datapath defined; that
  // result is never committed.
  function automatic logic [63:0] div_result(input logic [31:0] dvd,
                                             input logic [31:0] dvs,
                                             input logic        sgn);
    logic        neg_q, neg_r;
    logic [31:0] mag_n, mag_d, q, r;
    neg_q = sgn & (dvd[31] ^ dvs[31]);
    neg_r = sgn & dvd[31];
    mag_n = (sgn & dvd[31]) ? -dvd : dvd;
    mag_d = (sgn & dvs[31]) ? -dvs : dvs;
    if (mag_d == 32'd0) mag_d = 32'd1;
    q = mag_n / mag_d;
    r = mag_n % mag_d;
    if (neg_q) q = -q;
    if (neg_r) r = -r;
    return {r, q};
  endfunction

  always_comb begin
    is_mul = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU);
    is_div = (bus.MDUOp == MDU_DIV)  || (bus.MDUOp == MDU_DIVU);
    is_sgn = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_DIV);
    res    = is_mul ? mul_result(bus.A, bus.B, is_sgn)
                    : div_result(bus.A, bus.B, is_sgn);
  end

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (busy_q) begin
      // In-flight ops finish regardless of Req: they belong to an older,
      // already-committed instruction. New requests are dropped here.
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (!bus.Req) begin
      if (bus.Start && (is_mul || is_div)) begin
        busy_d    = 1'b1;
        cnt_d     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        pend_hi_d = res[63:32];
        pend_lo_d = res[31:0];
        // Divide by zero still occupies the unit but leaves HI/LO untouched.
        pend_wr_d = ~(is_div && (bus.B == 32'd0));
      end else if (bus.MDUOp == MDU_MTHI) begin
        hi_d = bus.A;
      end else if (bus.MDUOp == MDU_MTLO) begin
        lo_d = bus.A;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a vector table for the arithmetic,
// a scoreboard queue of expected {HI, LO, busy length}, and hand-written
// sequences for mthi/mtlo, Req cancel, ignored requests and async reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic reset;
  mult_div_unit_if mif ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.Start = 1'b0;
    mif.MDUOp = MDU_NONE;
    mif.A     = 32'd0;
    mif.B     = 32'd0;
  endtask

  // Present a mult/div for one cycle and push its expected outcome.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    mif.Start = 1'b1; mif.MDUOp = op; mif.A = a; mif.B = b;
    @(negedge clk);
    idle_inputs();
  endtask

  // Count Busy cycles until it drops, then pop and compare. With inject set,
  // a mult and then an mthi are presented while the unit is busy.
  task automatic wait_done(input string name, input bit inject);
    int   n;
    exp_t e;
    n = 0;
    while (mif.Busy === 1'b1 && n < 100) begin
      n++;
      if (inject && n == 2) begin
        mif.Start = 1'b1; mif.MDUOp = MDU_MULT; mif.A = 32'd2; mif.B = 32'd2;
      end else if (inject && n == 3) begin
        mif.Start = 1'b0; mif.MDUOp = MDU_MTHI; mif.A = 32'h99; mif.B = 32'd0;
      end else if (inject && n == 4) begin
        idle_inputs();
      end
      @(negedge clk);
    end
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sbq.pop_front();
      check({name, "_busy_cycles"}, 32'(n), 32'(e.cyc));
      check({name, "_hi"}, mif.HI, e.hi);
      check({name, "_lo"}, mif.LO, e.lo);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
    vecs[5] = '{MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};

    reset = 1'b1;
    mif.Req = 1'b0;
    idle_inputs();
    #1;
    check("reset_busy", {31'd0, mif.Busy}, 32'd0);
    check("reset_hi", mif.HI, 32'd0);
    check("reset_lo", mif.LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Arithmetic table
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);
      wait_done($sformatf("vec%0d", i), 1'b0);
    end

    // mthi / mtlo: one cycle, no Busy
    @(negedge clk);
    mif.MDUOp = MDU_MTHI; mif.A = 32'h11;
    @(negedge clk);
    idle_inputs();
    check("mthi_hi", mif.HI, 32'h11);
    check("mthi_busy", {31'd0, mif.Busy}, 32'd0);
    mif.MDUOp = MDU_MTLO; mif.A = 32'h22;
    @(negedge clk);
    idle_inputs();
    check("mtlo_lo", mif.LO, 32'h22);
    check("mtlo_busy", {31'd0, mif.Busy}, 32'd0);

    // Divide by zero: full latency, HI/LO unchanged
    issue(MDU_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 10);
    wait_done("div0", 1'b0);

    // Undefined encoding with Start: no effect
    @(negedge clk);
    mif.Start = 1'b1; mif.MDUOp = mdu_op_e'(3'd7); mif.A = 32'h1234; mif.B = 32'd1;
    @(negedge clk);
    idle_inputs();
    check("undef_busy", {31'd0, mif.Busy}, 32'd0);
    check("undef_hi", mif.HI, 32'h11);
    check("undef_lo", mif.LO, 32'h22);

    // Req cancels a Start
    mif.Start = 1'b1; mif.MDUOp = MDU_MULT; mif.A = 32'd3; mif.B = 32'd4; mif.Req = 1'b1;
    @(negedge clk);
    idle_inputs(); mif.Req = 1'b0;
    check("req_start_busy", {31'd0, mif.Busy}, 32'd0);
    @(negedge clk);
    check("req_start_busy2", {31'd0, mif.Busy}, 32'd0);
    check("req_start_hi", mif.HI, 32'h11);
    check("req_start_lo", mif.LO, 32'h22);

    // Req cancels an mtlo
    mif.MDUOp = MDU_MTLO; mif.A = 32'h55; mif.Req = 1'b1;
    @(negedge clk);
    idle_inputs(); mif.Req = 1'b0;
    check("req_mtlo_lo", mif.LO, 32'h22);

    // Req during an in-flight op does not stop it
    issue(MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    mif.Req = 1'b1;
    wait_done("req_inflight", 1'b0);
    mif.Req = 1'b0;

    // Start and mthi while busy are dropped
    issue(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_done("busy_ignore", 1'b1);
    @(negedge clk);
    check("busy_ignore_hi_late", mif.HI, 32'd2);
    check("busy_ignore_busy_late", {31'd0, mif.Busy}, 32'd0);

    // Async reset in cycle 3 of a div
    @(negedge clk);
    mif.Start = 1'b1; mif.MDUOp = MDU_DIV; mif.A = 32'd7; mif.B = 32'd2;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_busy", {31'd0, mif.Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_busy", {31'd0, mif.Busy}, 32'd0);
    check("rst_async_hi", mif.HI, 32'd0);
    check("rst_async_lo", mif.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int busy_seen;
      int hilo_seen;
      busy_seen = 0;
      hilo_seen = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (mif.Busy !== 1'b0) busy_seen++;
        if (mif.HI !== 32'd0 || mif.LO !== 32'd0) hilo_seen++;
      end
      check("rst_after_busy", 32'(busy_seen), 32'd0);
      check("rst_after_hilo", 32'(hilo_seen), 32'd0);
    end

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multiply/divide unit in the E stage. Executes mult/multu/div/divu over a fixed number of cycles and handles the mthi/mtlo writes. Owns the architectural HI/LO registers, whose outputs feed the write-back data selector for mfhi/mflo. Drives Busy to the hazard/stall unit, and honours an exception cancel (Req) from CP0 so that an instruction flushed by an interrupt or exception never changes HI/LO.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, Busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
Start  input  1  E-stage instruction is a mult/multu/div/divu; valid with MDUOp
MDUOp  input  3  operation select, encodings in macro.v
A  input  32  forwarded rs operand
B  input  32  forwarded rt operand
Req  input  1  CP0 exception/interrupt request; suppresses this cycle's Start and mthi/mtlo
Busy  output  1  computation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset: async, active-high. Busy=0, HI=0, LO=0, counter=0, pending results=0. An operation in flight is discarded with no HI/LO update.
- Accept condition: Start & ~Req & ~Busy at a rising edge.
  - On accept: compute the 64-bit result from A/B into pending_hi/pending_lo. Load counter with MULT_CYCLES or DIV_CYCLES. Busy=1 from the next cycle.
  - Start while Busy=1: ignored. The stall unit prevents this case, so it is not an error path.
- Counting: each edge with Busy=1 decrements counter.
  - At the edge where counter goes from 1 to 0: HI<=pending_hi, LO<=pending_lo, Busy<=0.
  - Busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles.
  - New HI/LO are visible in the first cycle Busy is low.
- Hazard contract: the stall unit stalls mfhi/mflo/mthi/mtlo/mult/div in D while (E-stage Start | Busy). The block itself does not need to order these cases.
- mthi/mtlo: when MDUOp=MTHI/MTLO & ~Req & ~Busy, HI<=A or LO<=A at the next edge. This takes one cycle and never asserts Busy. The same op while Busy=1 is ignored.
- Req=1: no accept and no mthi/mtlo in that cycle. An operation already in flight (Busy=1) completes normally, because it belongs to an older instruction that has already committed.
- Arithmetic:
  - mult: signed 32x32->64. multu: unsigned 32x32->64. HI = bits [63:32], LO = bits [31:0].
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): the op is still accepted and Busy runs the full DIV_CYCLES, but HI/LO keep their old values at completion.
- MDUOp=NONE or an undefined encoding with Start=1: treated as no operation. No state change, Busy stays 0.

Decomposition:
- macro.v defines the MDUOp encodings: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
- The decoder emits Start for codes 1-4 only.
- The cycle constants stay as module parameters.
- No sub-module. The datapath is combinational (*, /, %) captured at accept, with a counter and a small state set (IDLE, RUN) encoded by Busy plus counter.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, Start 1 cycle -> Busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo (each visible the next cycle, Busy stays 0); div A=5, B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- Start=1 with Req=1 (mult 3x4) -> Busy stays 0, HI/LO unchanged; mtlo A=0x55 with Req=1 -> LO unchanged; Req asserted while Busy=1 from an earlier mult 3x4 -> completes with LO=12.
- Assert reset asynchronously in cycle 3 of a div -> Busy, HI and LO go to 0 immediately without a clock edge; after release, Busy stays 0 and there is no late HI/LO update.
- Start (mult 2x2) and mthi A=0x99 presented while Busy=1 -> both ignored; the in-flight result commits unchanged and Busy returns to 0 on schedule.
